// File: rtl/sr_register_bank.sv
// rtl/sr_register_bank.sv - bank of independent SR channels with conflict flag and saturating counter
module sr_register_bank #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Resolution of a channel whose set and clr are both high; MODE is fixed
  // per instance, so this collapses to a constant or a wire after elaboration.
  function automatic logic resolve_both(input logic cur);
    case (MODE)
      0:       resolve_both = 1'b0;
      1:       resolve_both = 1'b1;
      2:       resolve_both = ~cur;
      default: resolve_both = cur;
    endcase
  endfunction

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] both_req;
  logic             any_conflict;
  logic             cnt_saturated;

  assign both_req      = set & clr;
  assign any_conflict  = |both_req;
  assign cnt_saturated = &conflict_cnt;

  // Complement output is purely combinational from the register, so it can
  // never be observed equal to q, including during reset.
  assign qbar = ~q;

  // Per-channel next-state; channels never look at one another.
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({set[i], clr[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11:   q_next[i] = resolve_both(q[i]);
        default: q_next[i] = q[i];
      endcase
    end
  end

  // Channel state plus the per-channel change pulse; both freeze with en low.
  // Reset clears changed so a release never produces a spurious pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      changed <= '0;
    end else if (en) begin
      q       <= q_next;
      changed <= q_next ^ q;
    end
  end

  // Registered conflict flag, independent of how MODE resolves the conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict <= 1'b0;
    end else if (en) begin
      conflict <= any_conflict;
    end
  end

  // Saturating conflict counter; cnt_clr wins over an increment and works
  // even while the bank is frozen by en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (cnt_clr) begin
      conflict_cnt <= '0;
    end else if (en && any_conflict && !cnt_saturated) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_register_bank.sv
// tb/tb_sr_register_bank.sv - directed self-checking bench for sr_register_bank
module tb_sr_register_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] set;
  logic [3:0] clr;
  logic       cnt_clr;

  logic [3:0] q0, q1, q2, q3;
  logic [3:0] qb0, qb1, qb2, qb3;
  logic [3:0] ch0, ch1, ch2, ch3;
  logic       cf0, cf1, cf2, cf3;
  logic [1:0] cn0, cn1, cn2, cn3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sr_register_bank #(.WIDTH(4), .MODE(0), .CNT_W(2)) u_m0 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q0), .qbar(qb0), .changed(ch0), .conflict(cf0), .conflict_cnt(cn0));
  sr_register_bank #(.WIDTH(4), .MODE(1), .CNT_W(2)) u_m1 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q1), .qbar(qb1), .changed(ch1), .conflict(cf1), .conflict_cnt(cn1));
  sr_register_bank #(.WIDTH(4), .MODE(2), .CNT_W(2)) u_m2 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q2), .qbar(qb2), .changed(ch2), .conflict(cf2), .conflict_cnt(cn2));
  sr_register_bank #(.WIDTH(4), .MODE(3), .CNT_W(2)) u_m3 (
    .clk(clk), .reset(reset), .en(en), .set(set), .clr(clr), .cnt_clr(cnt_clr),
    .q(q3), .qbar(qb3), .changed(ch3), .conflict(cf3), .conflict_cnt(cn3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (q0 !== 4'b0000) begin n_fail++; $display("FAIL reset_q: got %b want 0000", q0); end
    n_cmp++; if (qb0 !== 4'b1111) begin n_fail++; $display("FAIL reset_qbar: got %b want 1111", qb0); end
    n_cmp++; if (ch0 !== 4'b0000) begin n_fail++; $display("FAIL reset_changed: got %b want 0000", ch0); end
    n_cmp++; if (cf0 !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", cf0); end
    n_cmp++; if (cn0 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cn0); end
    en = 1'b1; set = 4'b1111; clr = 4'b1111;
    step();
    n_cmp++; if (q0 !== 4'b0000 || cf0 !== 1'b0 || cn0 !== 2'd0) begin
      n_fail++; $display("FAIL reset_held_edge: got q=%b cf=%b cnt=%0d want q=0000 cf=0 cnt=0", q0, cf0, cn0);
    end
    set = 4'b0000; clr = 4'b0000;
    #2 reset = 1'b0;
  endtask

  task automatic test_set();
    set = 4'b0101; clr = 4'b0000;
    step();
    set = 4'b0000;
    n_cmp++; if (q0 !== 4'b0101) begin n_fail++; $display("FAIL set_q: got %b want 0101", q0); end
    n_cmp++; if (qb0 !== 4'b1010) begin n_fail++; $display("FAIL set_qbar: got %b want 1010", qb0); end
    n_cmp++; if (ch0 !== 4'b0101) begin n_fail++; $display("FAIL set_changed: got %b want 0101", ch0); end
    step();
    n_cmp++; if (ch0 !== 4'b0000) begin n_fail++; $display("FAIL set_changed_drop: got %b want 0000", ch0); end
    n_cmp++; if (q0 !== 4'b0101) begin n_fail++; $display("FAIL set_hold: got %b want 0101", q0); end
  endtask

  task automatic test_independent();
    set = 4'b1000; clr = 4'b0001;
    step();
    n_cmp++; if (q0 !== 4'b1100) begin n_fail++; $display("FAIL indep_q: got %b want 1100", q0); end
    n_cmp++; if (ch0 !== 4'b1001) begin n_fail++; $display("FAIL indep_changed: got %b want 1001", ch0); end
    set = 4'b0100; clr = 4'b0000;
    step();
    n_cmp++; if (q0 !== 4'b1100) begin n_fail++; $display("FAIL redundant_set_q: got %b want 1100", q0); end
    n_cmp++; if (ch0 !== 4'b0000) begin n_fail++; $display("FAIL redundant_set_changed: got %b want 0000", ch0); end
    n_cmp++; if (cf0 !== 1'b0) begin n_fail++; $display("FAIL no_conflict: got %b want 0", cf0); end
  endtask

  task automatic test_modes();
    set = 4'b0011; clr = 4'b1100;
    step();
    n_cmp++; if (q0 !== 4'b0011 || q1 !== 4'b0011 || q2 !== 4'b0011 || q3 !== 4'b0011) begin
      n_fail++; $display("FAIL modes_prep: got %b %b %b %b want 0011 each", q0, q1, q2, q3);
    end
    set = 4'b1111; clr = 4'b1111;
    step();
    set = 4'b0000; clr = 4'b0000;
    n_cmp++; if (q0 !== 4'b0000) begin n_fail++; $display("FAIL mode0_q: got %b want 0000", q0); end
    n_cmp++; if (q1 !== 4'b1111) begin n_fail++; $display("FAIL mode1_q: got %b want 1111", q1); end
    n_cmp++; if (q2 !== 4'b1100) begin n_fail++; $display("FAIL mode2_q: got %b want 1100", q2); end
    n_cmp++; if (q3 !== 4'b0011) begin n_fail++; $display("FAIL mode3_q: got %b want 0011", q3); end
    n_cmp++; if ({cf0, cf1, cf2, cf3} !== 4'b1111) begin
      n_fail++; $display("FAIL modes_conflict: got %b want 1111", {cf0, cf1, cf2, cf3});
    end
    n_cmp++; if (ch0 !== 4'b0011 || ch2 !== 4'b1111 || ch3 !== 4'b0000) begin
      n_fail++; $display("FAIL modes_changed: got %b %b %b want 0011 1111 0000", ch0, ch2, ch3);
    end
    n_cmp++; if (qb2 !== 4'b0011) begin n_fail++; $display("FAIL mode2_qbar: got %b want 0011", qb2); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_cmp++; if (cn0 !== 2'd0 || cf0 !== 1'b0) begin
      n_fail++; $display("FAIL cnt_clear_idle: got cnt=%0d cf=%b want cnt=0 cf=0", cn0, cf0);
    end
    set = 4'b0001; clr = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (cn0 !== exp_cnt[k]) begin
        n_fail++; $display("FAIL cnt_step%0d: got %0d want %0d", k, cn0, exp_cnt[k]);
      end
    end
    set = 4'b0011; clr = 4'b0011;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    set = 4'b0000; clr = 4'b0000;
    n_cmp++; if (cn0 !== 2'd0) begin n_fail++; $display("FAIL cnt_clr_wins: got %0d want 0", cn0); end
    n_cmp++; if (cf0 !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_conflict: got %b want 1", cf0); end
  endtask

  task automatic test_enable();
    set = 4'b1010; clr = 4'b1000;
    step();
    n_cmp++; if (q0 !== 4'b0010 || ch0 !== 4'b0010 || cf0 !== 1'b1 || cn0 !== 2'd1) begin
      n_fail++; $display("FAIL en_prep: got q=%b ch=%b cf=%b cnt=%0d want q=0010 ch=0010 cf=1 cnt=1", q0, ch0, cf0, cn0);
    end
    en = 1'b0; set = 4'b1111; clr = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (q0 !== 4'b0010 || ch0 !== 4'b0010 || cf0 !== 1'b1 || cn0 !== 2'd1) begin
        n_fail++; $display("FAIL en_freeze%0d: got q=%b ch=%b cf=%b cnt=%0d want q=0010 ch=0010 cf=1 cnt=1", k, q0, ch0, cf0, cn0);
      end
    end
    en = 1'b1;
    step();
    n_cmp++; if (q0 !== 4'b1111 || ch0 !== 4'b1101 || cf0 !== 1'b0 || cn0 !== 2'd1) begin
      n_fail++; $display("FAIL en_resume: got q=%b ch=%b cf=%b cnt=%0d want q=1111 ch=1101 cf=0 cnt=1", q0, ch0, cf0, cn0);
    end
    en = 1'b0; set = 4'b0000; clr = 4'b1111; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; clr = 4'b0000;
    n_cmp++; if (cn0 !== 2'd0 || q0 !== 4'b1111 || ch0 !== 4'b1101) begin
      n_fail++; $display("FAIL cnt_clr_disabled: got cnt=%0d q=%b ch=%b want cnt=0 q=1111 ch=1101", cn0, q0, ch0);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (q0 !== 4'b0000 || qb0 !== 4'b1111 || ch0 !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset: got q=%b qbar=%b ch=%b want q=0000 qbar=1111 ch=0000", q0, qb0, ch0);
    end
    #2 reset = 1'b0;
    step();
    n_cmp++; if (ch0 !== 4'b0000 || q0 !== 4'b0000) begin
      n_fail++; $display("FAIL release_idle: got q=%b ch=%b want q=0000 ch=0000", q0, ch0);
    end
    step();
    n_cmp++; if (ch0 !== 4'b0000) begin n_fail++; $display("FAIL release_idle2: got %b want 0000", ch0); end
    reset = 1'b1;
    set = 4'b0100;
    #2 reset = 1'b0;
    step();
    set = 4'b0000;
    n_cmp++; if (q0 !== 4'b0100 || ch0 !== 4'b0100) begin
      n_fail++; $display("FAIL release_request: got q=%b ch=%b want q=0100 ch=0100", q0, ch0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; set = 4'b0000; clr = 4'b0000; cnt_clr = 1'b0;
    test_reset();
    test_set();
    test_independent();
    test_modes();
    test_saturate();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
